// File: rtl/calculadora_pkg.sv
// Shared definitions for the calculator front end: debouncer state encodings and the default
// stable-time count for the board clock.
package calculadora_pkg;

    typedef enum logic [1:0] {
        ESTABLE_0   = 2'b00,
        VALIDANDO_1 = 2'b01,
        ESTABLE_1   = 2'b10,
        VALIDANDO_0 = 2'b11
    } estado_t;

    // 10 ms of stable input at 100 MHz
    localparam int unsigned N_CICLOS_DEF = 1_000_000;

    function automatic logic nivel_limpio(input estado_t e);
        return (e == ESTABLE_1) || (e == VALIDANDO_0);
    endfunction

    function automatic logic en_validacion(input estado_t e);
        return (e == VALIDANDO_1) || (e == VALIDANDO_0);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages clear to 0 on reset.
module sincronizador_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/antirrebote_boton.sv
// Push-button debouncer: synchronizes boton_in, requires N_CICLOS+1 stable samples to accept a
// change, and emits registered level and edge strobes. Define ANTIRREBOTE_PULSO_BAJADA_EN for pulso_bajada.
module antirrebote_boton
    import calculadora_pkg::*;
#(
    parameter int unsigned N_CICLOS = N_CICLOS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic boton_limpio,
    output logic pulso_subida,
`ifdef ANTIRREBOTE_PULSO_BAJADA_EN
    output logic pulso_bajada,
`endif
    output logic validando
);

    localparam int unsigned CNT_W = $clog2(N_CICLOS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_CICLOS - 1);

    logic             boton_s;
    estado_t          estado, estado_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pulso_subida_n;
`ifdef ANTIRREBOTE_PULSO_BAJADA_EN
    logic             pulso_bajada_n;
`endif

    sincronizador_2ff u_sinc (
        .clk   (clk),
        .reset (reset),
        .d     (boton_in),
        .q     (boton_s)
    );

    // Next state; cnt falls back to 0 whenever it is not advancing so it reads 0 outside validation
    always_comb begin
        estado_n       = estado;
        cnt_n          = '0;
        pulso_subida_n = 1'b0;
`ifdef ANTIRREBOTE_PULSO_BAJADA_EN
        pulso_bajada_n = 1'b0;
`endif
        case (estado)
            ESTABLE_0: begin
                if (boton_s) estado_n = VALIDANDO_1;
            end
            VALIDANDO_1: begin
                if (!boton_s) begin
                    estado_n = ESTABLE_0;
                end else if (cnt == CNT_MAX) begin
                    estado_n       = ESTABLE_1;
                    pulso_subida_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ESTABLE_1: begin
                if (!boton_s) estado_n = VALIDANDO_0;
            end
            VALIDANDO_0: begin
                if (boton_s) begin
                    estado_n = ESTABLE_1;
                end else if (cnt == CNT_MAX) begin
                    estado_n       = ESTABLE_0;
`ifdef ANTIRREBOTE_PULSO_BAJADA_EN
                    pulso_bajada_n = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: estado_n = ESTABLE_0;
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= ESTABLE_0;
            cnt          <= '0;
            boton_limpio <= 1'b0;
            validando    <= 1'b0;
            pulso_subida <= 1'b0;
`ifdef ANTIRREBOTE_PULSO_BAJADA_EN
            pulso_bajada <= 1'b0;
`endif
        end else begin
            estado       <= estado_n;
            cnt          <= cnt_n;
            boton_limpio <= nivel_limpio(estado_n);
            validando    <= en_validacion(estado_n);
            pulso_subida <= pulso_subida_n;
`ifdef ANTIRREBOTE_PULSO_BAJADA_EN
            pulso_bajada <= pulso_bajada_n;
`endif
        end
    end

endmodule

// File: tb/tb_antirrebote_boton.sv
// Directed bench for antirrebote_boton with N_CICLOS=4 (acceptance after 5 samples, latency 7 edges).
module tb_antirrebote_boton;

    logic clk;
    logic reset;
    logic boton_in;
    logic boton_limpio;
    logic pulso_subida;
    logic pulso_bajada;
    logic validando;

`ifdef ANTIRREBOTE_PULSO_BAJADA_EN
    localparam int EXP_BAJ = 1;
`else
    localparam int EXP_BAJ = 0;
    assign pulso_bajada = 1'b0;
`endif

    antirrebote_boton #(.N_CICLOS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .boton_in     (boton_in),
        .boton_limpio (boton_limpio),
        .pulso_subida (pulso_subida),
`ifdef ANTIRREBOTE_PULSO_BAJADA_EN
        .pulso_bajada (pulso_bajada),
`endif
        .validando    (validando)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Observations from the last hold() window; edges are numbered from 1 within the window
    int obs_chg, obs_last, obs_val, obs_sub, obs_sub_edge, obs_baj, obs_tog;

    task automatic hold(input logic b, input int n);
        logic prev;
        prev = boton_limpio;
        obs_chg = 0; obs_last = 0; obs_val = 0; obs_sub = 0;
        obs_sub_edge = 0; obs_baj = 0; obs_tog = 0;
        for (int e = 1; e <= n; e++) begin
            boton_in = b;
            @(posedge clk);
            #1;
            if (boton_limpio !== prev) begin
                obs_tog++;
                if (obs_chg == 0) obs_chg = e;
                obs_last = e;
                prev = boton_limpio;
            end
            if (validando === 1'b1 && obs_val == 0) obs_val = e;
            if (pulso_subida === 1'b1) begin
                obs_sub++;
                if (obs_sub_edge == 0) obs_sub_edge = e;
            end
            if (pulso_bajada === 1'b1) obs_baj++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        boton_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({boton_limpio, validando, pulso_subida, pulso_bajada} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected 0000",
                         {boton_limpio, validando, pulso_subida, pulso_bajada});
            end
        end
        reset = 1'b0;
        hold(1'b1, 12);
        checks++;
        if (obs_chg !== 7) begin
            errors++; $display("FAIL reset_release_rise_edge: got %0d expected 7", obs_chg);
        end
        checks++;
        if (obs_sub !== 1 || obs_sub_edge !== 7) begin
            errors++;
            $display("FAIL reset_release_pulso_subida: got count %0d at edge %0d expected 1 at 7",
                     obs_sub, obs_sub_edge);
        end
        checks++;
        if (boton_limpio !== 1'b1) begin
            errors++; $display("FAIL reset_release_level: got %b expected 1", boton_limpio);
        end
    endtask

    task automatic test_release();
        hold(1'b0, 12);
        checks++;
        if (obs_val !== 3) begin
            errors++; $display("FAIL release_validando_edge: got %0d expected 3", obs_val);
        end
        checks++;
        if (obs_chg !== 7 || obs_tog !== 1) begin
            errors++;
            $display("FAIL release_fall: got edge %0d toggles %0d expected edge 7 toggles 1",
                     obs_chg, obs_tog);
        end
        checks++;
        if (obs_sub !== 0) begin
            errors++; $display("FAIL release_no_subida: got %0d expected 0", obs_sub);
        end
        checks++;
        if (obs_baj !== EXP_BAJ) begin
            errors++; $display("FAIL release_pulso_bajada: got %0d expected %0d", obs_baj, EXP_BAJ);
        end
        checks++;
        if (boton_limpio !== 1'b0) begin
            errors++; $display("FAIL release_level: got %b expected 0", boton_limpio);
        end
    endtask

    task automatic test_clean_press();
        hold(1'b1, 20);
        checks++;
        if (obs_val !== 3) begin
            errors++; $display("FAIL press_validando_edge: got %0d expected 3", obs_val);
        end
        checks++;
        if (obs_chg !== 7 || obs_tog !== 1) begin
            errors++;
            $display("FAIL press_rise: got edge %0d toggles %0d expected edge 7 toggles 1",
                     obs_chg, obs_tog);
        end
        checks++;
        if (obs_sub !== 1 || obs_sub_edge !== 7) begin
            errors++;
            $display("FAIL press_pulso_subida: got count %0d at edge %0d expected 1 at 7",
                     obs_sub, obs_sub_edge);
        end
        hold(1'b0, 12);
        checks++;
        if (boton_limpio !== 1'b0) begin
            errors++; $display("FAIL press_return_low: got %b expected 0", boton_limpio);
        end
    endtask

    task automatic test_bounce();
        int tog, sub;
        tog = 0;
        sub = 0;
        for (int r = 0; r < 3; r++) begin
            hold(1'b1, 3);
            tog += obs_tog; sub += obs_sub;
            hold(1'b0, 2);
            tog += obs_tog; sub += obs_sub;
        end
        checks++;
        if (tog !== 0 || sub !== 0) begin
            errors++;
            $display("FAIL bounce_quiet: got toggles %0d pulses %0d expected 0 0", tog, sub);
        end
        hold(1'b1, 12);
        checks++;
        if (obs_chg !== 7 || obs_sub !== 1 || obs_tog !== 1) begin
            errors++;
            $display("FAIL bounce_settle: got edge %0d pulses %0d toggles %0d expected 7 1 1",
                     obs_chg, obs_sub, obs_tog);
        end
        hold(1'b0, 12);
        checks++;
        if (boton_limpio !== 1'b0) begin
            errors++; $display("FAIL bounce_return_low: got %b expected 0", boton_limpio);
        end
    endtask

    task automatic test_glitch();
        int tog, sub;
        hold(1'b1, 4);
        tog = obs_tog; sub = obs_sub;
        hold(1'b0, 12);
        tog += obs_tog; sub += obs_sub;
        checks++;
        if (tog !== 0 || sub !== 0 || boton_limpio !== 1'b0) begin
            errors++;
            $display("FAIL glitch4_rejected: got toggles %0d pulses %0d level %b expected 0 0 0",
                     tog, sub, boton_limpio);
        end
        hold(1'b1, 5);
        checks++;
        if (obs_tog !== 0) begin
            errors++; $display("FAIL glitch5_early: got toggles %0d expected 0", obs_tog);
        end
        hold(1'b0, 12);
        checks++;
        if (obs_chg !== 2 || obs_sub !== 1 || obs_sub_edge !== 2) begin
            errors++;
            $display("FAIL glitch5_accept: got rise %0d pulses %0d at %0d expected 2 1 2",
                     obs_chg, obs_sub, obs_sub_edge);
        end
        checks++;
        if (obs_last !== 7 || obs_tog !== 2 || boton_limpio !== 1'b0) begin
            errors++;
            $display("FAIL glitch5_fall: got edge %0d toggles %0d level %b expected 7 2 0",
                     obs_last, obs_tog, boton_limpio);
        end
    endtask

    task automatic test_reset_mid();
        hold(1'b1, 4);
        checks++;
        if (validando !== 1'b1 || boton_limpio !== 1'b0) begin
            errors++;
            $display("FAIL midreset_validating: got validando %b level %b expected 1 0",
                     validando, boton_limpio);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({boton_limpio, validando, pulso_subida, pulso_bajada} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 0000",
                     {boton_limpio, validando, pulso_subida, pulso_bajada});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold(1'b0, 10);
        checks++;
        if (obs_sub !== 0 || obs_tog !== 0 || obs_val !== 0) begin
            errors++;
            $display("FAIL midreset_discarded: got pulses %0d toggles %0d val %0d expected 0 0 0",
                     obs_sub, obs_tog, obs_val);
        end
    endtask

    initial begin
        reset = 1'b1;
        boton_in = 1'b0;
        test_reset();
        test_release();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
